// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC configuration datapath:
// field codes, edit-FSM state encoding and default timing constants.
package rtc_pkg;

    localparam logic [3:0] FIELD_NONE  = 4'd0;
    localparam logic [3:0] FIELD_SEC   = 4'd1;
    localparam logic [3:0] FIELD_MIN   = 4'd2;
    localparam logic [3:0] FIELD_HOUR  = 4'd3;
    localparam logic [3:0] FIELD_TSEC  = 4'd4;
    localparam logic [3:0] FIELD_TMIN  = 4'd5;
    localparam logic [3:0] FIELD_DAY   = 4'd6;
    localparam logic [3:0] FIELD_MONTH = 4'd7;
    localparam logic [3:0] FIELD_YEAR  = 4'd8;
    localparam logic [3:0] FIELD_THOUR = 4'd9;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } edit_state_t;

    localparam int unsigned DEF_NUM_FIELDS    = 9;
    localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD = 25_000_000;
    localparam int unsigned DEF_TIMEOUT       = 1_000_000_000;

    function automatic logic [3:0] field_next(input logic [3:0] f, input int unsigned n);
        return (f >= 4'(n)) ? FIELD_SEC : f + 4'd1;
    endfunction

    function automatic logic [3:0] field_prev(input logic [3:0] f, input int unsigned n);
        return (f <= FIELD_SEC) ? 4'(n) : f - 4'd1;
    endfunction

endpackage

// File: rtl/rtc_edit_sequencer_if.sv
// Button, commit-handshake and field-control signals between the board/RTC
// write controller and the edit sequencer.
interface rtc_edit_sequencer_if;
    logic       btn_cfg;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       commit_ack;
    logic [3:0] field_sel;
    logic       step_up;
    logic       step_down;
    logic       edit_active;
    logic       commit_req;

    modport master (
        input  btn_cfg, btn_left, btn_right, btn_up, btn_down, commit_ack,
        output field_sel, step_up, step_down, edit_active, commit_req
    );

    modport slave (
        output btn_cfg, btn_left, btn_right, btn_up, btn_down, commit_ack,
        input  field_sel, step_up, step_down, edit_active, commit_req
    );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw push-button level followed by a registered
// rising-edge detector; level and rise are aligned to the same cycle.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);
    logic meta;
    logic sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            level <= sync;
            rise  <= sync & ~level;
        end
    end
endmodule

// File: rtl/rtc_edit_sequencer.sv
// Edit-mode sequencer: button decoding, field selection, up/down step pulses
// with auto-repeat, inactivity timeout and commit handshake.
module rtc_edit_sequencer
    import rtc_pkg::*;
#(
    parameter int unsigned NUM_FIELDS    = DEF_NUM_FIELDS,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
    input logic                 clk,
    input logic                 reset,
    rtc_edit_sequencer_if.master io
);
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    logic cfg_lvl, left_lvl, right_lvl, up_lvl, dn_lvl;
    logic cfg_r, left_r, right_r, up_r, dn_r;

    btn_sync_edge u_cfg   (.clk(clk), .reset(reset), .btn(io.btn_cfg),   .level(cfg_lvl),   .rise(cfg_r));
    btn_sync_edge u_left  (.clk(clk), .reset(reset), .btn(io.btn_left),  .level(left_lvl),  .rise(left_r));
    btn_sync_edge u_right (.clk(clk), .reset(reset), .btn(io.btn_right), .level(right_lvl), .rise(right_r));
    btn_sync_edge u_up    (.clk(clk), .reset(reset), .btn(io.btn_up),    .level(up_lvl),    .rise(up_r));
    btn_sync_edge u_down  (.clk(clk), .reset(reset), .btn(io.btn_down),  .level(dn_lvl),    .rise(dn_r));

    logic unused;
    assign unused = &{1'b0, cfg_lvl, left_lvl, right_lvl};

    edit_state_t   state, state_nx;
    logic [3:0]    field_q, field_nx;
    logic          step_up_q, step_up_nx, step_dn_q, step_dn_nx;
    logic          edit_q, req_q;
    logic [RW-1:0] rep_cnt, rep_nx;
    logic          rpt, rpt_nx, held, held_nx, held_up, held_up_nx;
    logic [IW-1:0] idle_cnt, idle_nx;
    logic          field_move, fire, up_only, dn_only, any_rise;

    always_comb begin
        state_nx   = state;
        field_nx   = field_q;
        field_move = 1'b0;
        any_rise   = cfg_r | left_r | right_r | up_r | dn_r;
        unique case (state)
            ST_RUN: begin
                field_nx = FIELD_NONE;
                if (cfg_r) begin
                    state_nx = ST_EDIT;
                    field_nx = FIELD_SEC;
                end
            end
            ST_EDIT: begin
                if (cfg_r || idle_cnt == IW'(TIMEOUT - 1)) begin
                    state_nx = ST_COMMIT;
                    field_nx = FIELD_NONE;
                end else if (right_r && !left_r) begin
                    field_nx   = field_next(field_q, NUM_FIELDS);
                    field_move = 1'b1;
                end else if (left_r && !right_r) begin
                    field_nx   = field_prev(field_q, NUM_FIELDS);
                    field_move = 1'b1;
                end
            end
            ST_COMMIT: begin
                field_nx = FIELD_NONE;
                if (io.commit_ack) state_nx = ST_RUN;
            end
            default: begin
                state_nx = ST_RUN;
                field_nx = FIELD_NONE;
            end
        endcase
    end

    // One repeat counter shared by both directions; a direction change without
    // an intervening release is treated as a fresh press.
    always_comb begin
        up_only    = up_lvl & ~dn_lvl;
        dn_only    = dn_lvl & ~up_lvl;
        fire       = 1'b0;
        rep_nx     = rep_cnt;
        rpt_nx     = rpt;
        held_nx    = held;
        held_up_nx = held_up;
        if (state != ST_EDIT || state_nx != ST_EDIT || !(up_only || dn_only)) begin
            rep_nx  = '0;
            rpt_nx  = 1'b0;
            held_nx = 1'b0;
        end else if (!field_move) begin
            if (!held || held_up != up_only) begin
                fire       = 1'b1;
                rep_nx     = '0;
                rpt_nx     = 1'b0;
                held_nx    = 1'b1;
                held_up_nx = up_only;
            end else if ((!rpt && rep_cnt == RW'(REPEAT_DELAY - 1)) ||
                         ( rpt && rep_cnt == RW'(REPEAT_PERIOD - 1))) begin
                fire   = 1'b1;
                rep_nx = '0;
                rpt_nx = 1'b1;
            end else begin
                rep_nx = rep_cnt + RW'(1);
            end
        end
        step_up_nx = fire & up_only;
        step_dn_nx = fire & dn_only;

        idle_nx = idle_cnt;
        if (state != ST_EDIT || any_rise || fire) idle_nx = '0;
        else if (idle_cnt != IW'(TIMEOUT - 1)) idle_nx = idle_cnt + IW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            field_q   <= FIELD_NONE;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            edit_q    <= 1'b0;
            req_q     <= 1'b0;
            rep_cnt   <= '0;
            rpt       <= 1'b0;
            held      <= 1'b0;
            held_up   <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_nx;
            field_q   <= field_nx;
            step_up_q <= step_up_nx;
            step_dn_q <= step_dn_nx;
            edit_q    <= (state_nx != ST_RUN);
            req_q     <= (state_nx == ST_COMMIT);
            rep_cnt   <= rep_nx;
            rpt       <= rpt_nx;
            held      <= held_nx;
            held_up   <= held_up_nx;
            idle_cnt  <= idle_nx;
        end
    end

    assign io.field_sel   = field_q;
    assign io.step_up     = step_up_q;
    assign io.step_down   = step_dn_q;
    assign io.edit_active = edit_q;
    assign io.commit_req  = req_q;
endmodule

// File: tb/tb_rtc_edit_sequencer.sv
// Scoreboard bench for rtc_edit_sequencer: every change of the output tuple
// must match the next expected {cycle, outputs} entry queued by the stimulus.
module tb_rtc_edit_sequencer;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int unsigned NF = 9;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;
    localparam int unsigned TO = 100;

    localparam int B_CFG = 0, B_LEFT = 1, B_RIGHT = 2, B_UP = 3, B_DN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  btn = '0;
    logic        ack = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    rtc_edit_sequencer_if bus ();

    assign bus.btn_cfg    = btn[B_CFG];
    assign bus.btn_left   = btn[B_LEFT];
    assign bus.btn_right  = btn[B_RIGHT];
    assign bus.btn_up     = btn[B_UP];
    assign bus.btn_down   = btn[B_DN];
    assign bus.commit_ack = ack;

    rtc_edit_sequencer #(
        .NUM_FIELDS   (NF),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .TIMEOUT      (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  out;
    } ev_t;

    ev_t sb[$];

    logic [3:0] m_field = 4'd0;
    logic       m_act = 1'b0;
    logic       m_req = 1'b0;

    function automatic logic [7:0] pk(input logic [3:0] f, input logic u, input logic d,
                                      input logic a, input logic r);
        return {f, u, d, a, r};
    endfunction

    function automatic logic [7:0] dut_out();
        return pk(bus.field_sel, bus.step_up, bus.step_down, bus.edit_active, bus.commit_req);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int unsigned c, input logic [7:0] o);
        sb.push_back('{c, o});
    endtask

    task automatic push_model(input int unsigned c);
        push_ev(c, pk(m_field, 1'b0, 1'b0, m_act, m_req));
    endtask

    task automatic push_pulse(input int unsigned c, input bit up);
        push_ev(c, pk(m_field, up, !up, m_act, m_req));
        push_model(c + 1);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) tick(1);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        tick(4);
        btn[b] = 1'b0;
        tick(4);
    endtask

    // Model must already hold the post-press state when changes is set.
    task automatic press_ev(input int b, input bit changes);
        if (changes) push_model(cyc + 4);
        press(b);
    endtask

    logic [7:0] prev_out = '0;
    always @(negedge clk) begin
        logic [7:0] cur;
        ev_t        e;
        cur = dut_out();
        if (cur != prev_out) begin
            if (sb.size() == 0) begin
                check("extra_event", 32'(cur), 32'(prev_out));
            end else begin
                e = sb.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_outputs", 32'(cur), 32'(e.out));
            end
        end
        prev_out = cur;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 100000", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned t0, t1, tc, last;

        tick(3);
        check("reset_outputs", 32'(dut_out()), 32'd0);
        reset = 1'b0;
        tick(2);

        // entry and wrap
        m_field = 4'd1; m_act = 1'b1; m_req = 1'b0;
        press_ev(B_CFG, 1'b1);
        for (int i = 0; i < 9; i++) begin
            m_field = (m_field == 4'(NF)) ? 4'd1 : m_field + 4'd1;
            press_ev(B_RIGHT, 1'b1);
        end
        m_field = 4'(NF);
        press_ev(B_LEFT, 1'b1);
        btn[B_LEFT] = 1'b1; btn[B_RIGHT] = 1'b1;
        tick(4);
        btn[B_LEFT] = 1'b0; btn[B_RIGHT] = 1'b0;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            m_field = m_field - 4'd1;
            press_ev(B_LEFT, 1'b1);
        end

        // day edit with auto-repeat
        t0 = cyc + 4;
        for (int i = 0; i < 5; i++)
            push_pulse(t0 + ((i == 0) ? 0 : RD + RP * (i - 1)), 1'b1);
        btn[B_UP] = 1'b1;
        tick(49);
        btn[B_UP] = 1'b0;
        tick(4);

        // up+down conflict, then release down
        btn[B_UP] = 1'b1; btn[B_DN] = 1'b1;
        tick(60);
        btn[B_DN] = 1'b0;
        t1 = cyc + 4;
        push_pulse(t1, 1'b1);
        push_pulse(t1 + RD, 1'b1);
        tick(26);
        btn[B_UP] = 1'b0;
        last = t1 + RD;

        // inactivity timeout
        tc = last + TO;
        m_field = 4'd0; m_req = 1'b1;
        push_model(tc);
        wait_cyc(tc + 3);
        check("commit_hold", 32'(dut_out()), 32'(pk(4'd0, 1'b0, 1'b0, 1'b1, 1'b1)));
        wait_cyc(tc + 5);
        m_act = 1'b0; m_req = 1'b0;
        push_model(cyc + 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(3);

        // manual exit, ignored presses in COMMIT, ack in RUN
        m_field = 4'd1; m_act = 1'b1;
        press_ev(B_CFG, 1'b1);
        m_field = 4'd0; m_req = 1'b1;
        press_ev(B_CFG, 1'b1);
        press_ev(B_RIGHT, 1'b0);
        press_ev(B_UP, 1'b0);
        m_act = 1'b0; m_req = 1'b0;
        push_model(cyc + 1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(3);
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        tick(3);

        // ack in the cycle COMMIT is entered
        m_field = 4'd1; m_act = 1'b1;
        press_ev(B_CFG, 1'b1);
        m_field = 4'd0; m_req = 1'b1;
        push_model(cyc + 4);
        m_act = 1'b0; m_req = 1'b0;
        push_model(cyc + 5);
        btn[B_CFG] = 1'b1;
        tick(4);
        btn[B_CFG] = 1'b0;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(4);

        // async reset mid-repeat with down held
        m_field = 4'd1; m_act = 1'b1;
        press_ev(B_CFG, 1'b1);
        btn[B_DN] = 1'b1;
        push_pulse(cyc + 4, 1'b0);
        tick(15);
        m_field = 4'd0; m_act = 1'b0;
        push_model(cyc);
        reset = 1'b1;
        #1;
        check("reset_mid_repeat", 32'(dut_out()), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(40);
        btn[B_DN] = 1'b0;
        tick(4);

        // async reset mid-COMMIT
        m_field = 4'd1; m_act = 1'b1;
        press_ev(B_CFG, 1'b1);
        m_field = 4'd0; m_req = 1'b1;
        push_model(cyc + 4);
        btn[B_CFG] = 1'b1;
        tick(4);
        btn[B_CFG] = 1'b0;
        tick(3);
        m_act = 1'b0; m_req = 1'b0;
        push_model(cyc);
        reset = 1'b1;
        #1;
        check("reset_mid_commit", 32'(dut_out()), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(10);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
